// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester and a
// data requester. Data has priority. Each granted request is latched, so requester
// inputs may change while the bus access is in flight. Completion is a one-cycle
// ready pulse, and that requester cannot be re-granted during its own pulse cycle.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   if_en_i, if_addr_i             fetch request, held until if_ready_o
//   if_rdata_o, if_ready_o         fetched word, one-cycle completion pulse
//   mem_en_i, mem_wen_i            data request, byte write enables (0 = read)
//   mem_addr_i, mem_wdata_i        data address and store data
//   mem_rdata_o, mem_ready_o       load data, one-cycle completion pulse
//   bus_en_o .. bus_wdata_o        shared memory port request (zero while idle)
//   bus_rdata_i, bus_ready_i       shared port read data and completion
//   stall_req_o                    pipeline stall while any request is outstanding
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_en_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ready_o,
  input  logic                  mem_en_i,
  input  logic [SEL_WIDTH-1:0]  mem_wen_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_ready_o,
  output logic                  bus_en_o,
  output logic [SEL_WIDTH-1:0]  bus_wen_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_ready_i,
  output logic                  stall_req_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_WIDTH-1:0]  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  mem_ready_q, mem_ready_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A requester whose ready pulse is showing still has its enable up this
        // cycle; masking it gives the one-cycle turnaround.
        if (mem_en_i && !mem_ready_q) begin
          state_d = StData;
          addr_d  = mem_addr_i;
          wen_d   = mem_wen_i;
          wdata_d = mem_wdata_i;
        end else if (if_en_i && !if_ready_q) begin
          state_d = StFetch;
          addr_d  = if_addr_i;
          wen_d   = '0;
          wdata_d = '0;
        end
      end
      StFetch: begin
        if (bus_ready_i) begin
          state_d    = StIdle;
          if_rdata_d = bus_rdata_i;
          if_ready_d = 1'b1;
        end
      end
      StData: begin
        if (bus_ready_i) begin
          state_d     = StIdle;
          mem_ready_d = 1'b1;
          if (wen_q == '0) begin
            mem_rdata_d = bus_rdata_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wen_q       <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Bus outputs are gated by state so the port reads all-zero while idle, and
  // drop the same instant an asynchronous reset forces the FSM to idle.
  always_comb begin
    bus_en_o    = (state_q != StIdle);
    bus_addr_o  = bus_en_o ? addr_q  : '0;
    bus_wen_o   = bus_en_o ? wen_q   : '0;
    bus_wdata_o = bus_en_o ? wdata_q : '0;
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ready_o = mem_ready_q;
  assign stall_req_o = (if_en_i & ~if_ready_q) | (mem_en_i & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        if_en_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        mem_en_i = 1'b0;
  logic [3:0]  mem_wen_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        bus_en_o;
  logic [3:0]  bus_wen_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ready_i = 1'b0;
  logic        stall_req_o;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_en_i(if_en_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .mem_en_i(mem_en_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
    .bus_en_o(bus_en_o), .bus_wen_o(bus_wen_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i),
    .stall_req_o(stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_rec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } req_t;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  bus_rec_t    bus_q[$];   // completed bus transfers, in completion order
  logic [31:0] exp_if[$];  // issued fetch addresses
  req_t        exp_mem[$]; // issued data requests
  logic [31:0] last_if;
  logic [31:0] last_mem;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // ---------------- randomized phase processes ----------------

  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      int waited = 0;
      for (int g = 0; g < gap; g++) @(negedge clk_i);
      if_addr_i = $urandom;
      if_en_i   = 1'b1;
      exp_if.push_back(if_addr_i);
      do begin
        @(negedge clk_i);
        waited++;
      end while (!if_ready_o && waited < 200);
      if (!if_ready_o) begin
        checks++;
        errors++;
        $display("FAIL fetch_timeout got=no_if_ready expected=if_ready");
      end
      if_en_i = 1'b0;
    end
  endtask

  task automatic run_data(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      int waited = 0;
      for (int g = 0; g < gap; g++) @(negedge clk_i);
      mem_addr_i  = $urandom;
      mem_wdata_i = $urandom;
      mem_wen_i   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      mem_en_i    = 1'b1;
      exp_mem.push_back('{addr: mem_addr_i, wen: mem_wen_i, wdata: mem_wdata_i});
      do begin
        @(negedge clk_i);
        waited++;
      end while (!mem_ready_o && waited < 200);
      if (!mem_ready_o) begin
        checks++;
        errors++;
        $display("FAIL data_timeout got=no_mem_ready expected=mem_ready");
      end
      mem_en_i = 1'b0;
    end
  endtask

  // Random-latency memory; also asserts stray bus_ready while idle.
  task automatic slave();
    bit       in_txn = 1'b0;
    bus_rec_t cur;
    while (!done) begin
      @(negedge clk_i);
      if (bus_en_o) begin
        if (in_txn) begin
          chk("bus_addr_stable", bus_addr_o, cur.addr);
          chk("bus_wen_stable", bus_wen_o, cur.wen);
          chk("bus_wdata_stable", bus_wdata_o, cur.wdata);
        end else begin
          cur    = '{addr: bus_addr_o, wen: bus_wen_o, wdata: bus_wdata_o, rdata: '0};
          in_txn = 1'b1;
        end
        bus_rdata_i = $urandom;
        bus_ready_i = ($urandom_range(0, 2) == 0);
        if (bus_ready_i) begin
          cur.rdata = bus_rdata_i;
          bus_q.push_back(cur);
          in_txn = 1'b0;
        end
      end else begin
        in_txn      = 1'b0;
        bus_rdata_i = $urandom;
        bus_ready_i = ($urandom_range(0, 7) == 0);
      end
    end
    bus_ready_i = 1'b0;
  endtask

  task automatic monitor();
    bus_rec_t r;
    req_t     m;
    logic [31:0] a;
    while (!done) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (if_ready_o && mem_ready_o) begin
        errors++;
        $display("FAIL both_ready got=11 expected=not_both");
      end
      chk("stall_req", stall_req_o,
          (if_en_i & ~if_ready_o) | (mem_en_i & ~mem_ready_o));
      if (!bus_en_o) begin
        chk("idle_bus_zero", {bus_addr_o, bus_wen_o, bus_wdata_o}, '0);
      end
      if (if_ready_o) begin
        if (exp_if.size() == 0 || bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_if_ready got=1 expected=0");
        end else begin
          a = exp_if.pop_front();
          r = bus_q.pop_front();
          chk("fetch_bus_addr", r.addr, a);
          chk("fetch_bus_wen", r.wen, 4'h0);
          chk("if_rdata", if_rdata_o, r.rdata);
          last_if = r.rdata;
        end
      end else begin
        chk("if_rdata_hold", if_rdata_o, last_if);
      end
      if (mem_ready_o) begin
        if (exp_mem.size() == 0 || bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_mem_ready got=1 expected=0");
        end else begin
          m = exp_mem.pop_front();
          r = bus_q.pop_front();
          chk("data_bus_addr", r.addr, m.addr);
          chk("data_bus_wen", r.wen, m.wen);
          chk("data_bus_wdata", r.wdata, m.wdata);
          if (m.wen == 4'h0) last_mem = r.rdata;
          chk("mem_rdata", mem_rdata_o, last_mem);
        end
      end else begin
        chk("mem_rdata_hold", mem_rdata_o, last_mem);
      end
    end
  endtask

  // ---------------- directed scenarios, then random traffic ----------------

  initial begin
    step();
    step();
    chk("rst_bus_en", bus_en_o, 1'b0);
    chk("rst_bus_fields", {bus_addr_o, bus_wen_o, bus_wdata_o}, '0);
    chk("rst_ready", {if_ready_o, mem_ready_o}, 2'b00);
    chk("rst_rdata", {if_rdata_o, mem_rdata_o}, '0);
    chk("rst_stall", stall_req_o, 1'b0);
    rst_ni = 1'b1;
    step();

    // Lone fetch with minimum latency.
    if_en_i = 1'b1; if_addr_i = 32'hBFC0_0000;
    #1 chk("lf_stall_c0", stall_req_o, 1'b1);
    step();
    chk("lf_bus_en", bus_en_o, 1'b1);
    chk("lf_bus_addr", bus_addr_o, 32'hBFC0_0000);
    chk("lf_bus_wen", bus_wen_o, 4'h0);
    chk("lf_stall_c1", stall_req_o, 1'b1);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h2402_0001;
    step();
    chk("lf_if_ready", if_ready_o, 1'b1);
    chk("lf_if_rdata", if_rdata_o, 32'h2402_0001);
    chk("lf_stall_c2", stall_req_o, 1'b0);
    if_en_i = 1'b0; bus_ready_i = 1'b0;
    step();
    chk("lf_pulse_end", if_ready_o, 1'b0);
    chk("lf_bus_idle", bus_en_o, 1'b0);

    // Read with three wait states.
    mem_en_i = 1'b1; mem_wen_i = 4'h0; mem_addr_i = 32'h40;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("ws_bus_en", bus_en_o, 1'b1);
      chk("ws_bus_addr", bus_addr_o, 32'h40);
      chk("ws_no_ready", mem_ready_o, 1'b0);
      bus_rdata_i = 32'hCAFE_0041 ^ 32'(3 - c);
      bus_ready_i = (c == 3);
    end
    step();
    chk("ws_mem_ready", mem_ready_o, 1'b1);
    chk("ws_mem_rdata", mem_rdata_o, 32'hCAFE_0041);
    mem_en_i = 1'b0; bus_ready_i = 1'b0;
    step();
    chk("ws_pulse_end", mem_ready_o, 1'b0);

    // Collision: data write wins, fetch follows in the pulse cycle.
    if_en_i = 1'b1; if_addr_i = 32'h0000_1000;
    mem_en_i = 1'b1; mem_wen_i = 4'hF; mem_addr_i = 32'h8000_0010; mem_wdata_i = 32'hDEAD_BEEF;
    step();
    chk("co_bus_addr", bus_addr_o, 32'h8000_0010);
    chk("co_bus_wen", bus_wen_o, 4'hF);
    chk("co_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    step();
    chk("co_readys", {mem_ready_o, if_ready_o}, 2'b10);
    chk("co_mem_rdata_kept", mem_rdata_o, 32'hCAFE_0041);
    mem_en_i = 1'b0; bus_ready_i = 1'b0;
    step();
    chk("co_fetch_bus", {bus_en_o, bus_addr_o, bus_wen_o}, {1'b1, 32'h0000_1000, 4'h0});
    bus_ready_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    step();
    chk("co_if_ready", {mem_ready_o, if_ready_o}, 2'b01);
    chk("co_if_rdata", if_rdata_o, 32'h1234_5678);
    chk("co_mem_rdata_end", mem_rdata_o, 32'hCAFE_0041);
    if_en_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Requester input change while in flight.
    mem_en_i = 1'b1; mem_wen_i = 4'h0; mem_addr_i = 32'h10;
    step();
    chk("ic_bus_addr0", bus_addr_o, 32'h10);
    mem_addr_i = 32'h20;
    step();
    chk("ic_bus_addr1", bus_addr_o, 32'h10);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    step();
    chk("ic_mem_ready", mem_ready_o, 1'b1);
    mem_en_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Stray bus_ready while idle.
    bus_ready_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    step();
    chk("st_no_ready", {if_ready_o, mem_ready_o, bus_en_o}, 3'b000);
    bus_ready_i = 1'b0;
    step();
    chk("st_no_ready2", {if_ready_o, mem_ready_o, bus_en_o}, 3'b000);
    chk("st_rdata_kept", mem_rdata_o, 32'h5555_AAAA);

    // Asynchronous reset in the middle of a data access.
    mem_en_i = 1'b1; mem_wen_i = 4'h0; mem_addr_i = 32'h30;
    step();
    chk("ra_bus_en", bus_en_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ra_bus_dropped", {bus_en_o, bus_addr_o}, '0);
    chk("ra_no_ready", mem_ready_o, 1'b0);
    step();
    chk("ra_no_ready2", mem_ready_o, 1'b0);
    rst_ni = 1'b1;
    step();
    chk("ra_regrant", {bus_en_o, bus_addr_o}, {1'b1, 32'h30});
    bus_ready_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    step();
    chk("ra_mem_ready", mem_ready_o, 1'b1);
    chk("ra_mem_rdata", mem_rdata_o, 32'h0BAD_F00D);
    mem_en_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Randomized concurrent traffic against the scoreboard.
    last_if  = 32'h0;
    last_mem = 32'h0BAD_F00D;
    fork
      begin
        fork
          run_fetch(150);
          run_data(150);
        join
        repeat (10) @(negedge clk_i);
        done = 1'b1;
      end
      slave();
      monitor();
    join
    chk("sb_bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("sb_if_q_empty", 64'(exp_if.size()), 64'd0);
    chk("sb_mem_q_empty", 64'(exp_mem.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
